// File: rtl/stack_datapath.sv
// LIFO datapath that saves and restores call frames for a small controller.
// Popped words are captured in three registered result outputs. Error flags stay set until cleared.
module stack_datapath #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [1:0]       pushSrc,
  input  logic [WIDTH-1:0] flagIn,
  input  logic [WIDTH-1:0] nIn,
  input  logic [WIDTH-1:0] retIn,
  input  logic             enF,
  input  logic             enN,
  input  logic             enRes,
  input  logic             clrErr,
  output logic [WIDTH-1:0] flagOut,
  output logic [WIDTH-1:0] nOut,
  output logic [WIDTH-1:0] resOut,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             protoErr
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      countReg;
  logic [WIDTH-1:0] pushWord;
  logic [WIDTH-1:0] topWord;
  logic [AW-1:0]    topAddr;
  logic             isEmpty;
  logic             isFull;
  logic             doPush;
  logic             doPop;
  logic [2:0]       outEn;
  logic [2:0]       errSet;

  always_comb begin
    pushWord = '0;
    case (pushSrc)
      2'd0:    pushWord = flagIn;
      2'd1:    pushWord = nIn;
      2'd2:    pushWord = retIn;
      default: pushWord = '0;
    endcase
  end

  assign isEmpty = (countReg == '0);
  assign isFull  = (countReg == (AW+1)'(DEPTH));
  assign doPush  = push & ~pop & ~isFull;
  assign doPop   = pop & ~push & ~isEmpty;
  assign topAddr = countReg[AW-1:0] - AW'(1);
  assign topWord = mem[topAddr];

  // Memory is never reset; stale words are unreachable once count is zero.
  always_ff @(posedge clk) begin
    if (!rst && doPush) begin
      mem[countReg[AW-1:0]] <= pushWord;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      countReg <= '0;
    end else if (doPush) begin
      countReg <= countReg + (AW+1)'(1);
    end else if (doPop) begin
      countReg <= countReg - (AW+1)'(1);
    end
  end

  // Result registers: index 0 = flag, 1 = N, 2 = result.
  assign outEn = {enRes, enN, enF};

  for (genvar gi = 0; gi < 3; gi++) begin : gOut
    logic [WIDTH-1:0] dataReg;
    always_ff @(posedge clk) begin
      if (rst) begin
        dataReg <= '0;
      end else if (doPop && outEn[gi]) begin
        dataReg <= topWord;
      end
    end
  end

  // Sticky errors: 0 = overflow, 1 = underflow, 2 = protocol. A new error beats clrErr.
  assign errSet = {push & pop, pop & ~push & isEmpty, push & ~pop & isFull};

  for (genvar gi = 0; gi < 3; gi++) begin : gErr
    logic flagReg;
    always_ff @(posedge clk) begin
      if (rst) begin
        flagReg <= 1'b0;
      end else if (errSet[gi]) begin
        flagReg <= 1'b1;
      end else if (clrErr) begin
        flagReg <= 1'b0;
      end
    end
  end

  assign flagOut   = gOut[0].dataReg;
  assign nOut      = gOut[1].dataReg;
  assign resOut    = gOut[2].dataReg;
  assign count     = countReg;
  assign empty     = isEmpty;
  assign full      = isFull;
  assign overflow  = gErr[0].flagReg;
  assign underflow = gErr[1].flagReg;
  assign protoErr  = gErr[2].flagReg;

endmodule
